i_cache_sa: RTL
===============

# i_cache_sa

Parametrised set-associative instruction cache between the IF stage and the DRAM line-fill port; next generation of the direct-mapped I-cache. Adds configurable ways, sets and line length, per-set round-robin replacement and a synchronous whole-cache flush. IF issues `Instr_req`/`IF_address`, gets `instruction`/`hit` one cycle later, and stalls on `rom_abort` while a miss is refilled from DRAM in `LINE_WORDS` 32-bit beats.

## Interface
- `WAYS`, 2: associativity; 1, 2 or 4.
- `SETS`, 256: sets per way; power of two, 16–1024.
- `LINE_WORDS`, 8: 32-bit words per line; 4, 8 or 16.
- Derived: `OFF_W=log2(LINE_WORDS)`, `IDX_W=log2(SETS)`, `TAG_W=30-OFF_W-IDX_W`; address fields: word offset `[OFF_W+1:2]`, index `[OFF_W+IDX_W+1:OFF_W+2]`, tag `[31:OFF_W+IDX_W+2]`.
- `CLK` in 1: single clock, all state on rising edge.
- `RESET` in 1: reset is synchronous and active-low.
- `IF_address` in 32: byte address of requested instruction.
- `Instr_req` in 1: lookup request.
- `flush` in 1: invalidate every line (one-cycle pulse).
- `DRAM_data` in 32: fill beat.
- `DRAM_valid` in 1: `DRAM_data` valid this cycle.
- `DRAM_req` out 1: line fill request, held until last beat.
- `DRAM_req_addr` out 32: line-aligned word address `{2'b0, miss_addr[31:OFF_W+2], OFF_W'b0}`.
- `instruction` out 32: selected word of the looked-up line.
- `hit` out 1: lookup of previous-cycle request hit.
- `rom_abort` out 1: IF must discard `instruction` and replay.
- `hit_count`, `miss_count` out 32: statistics (see Configuration).

## Operation
- Storage: per way, `SETS` × (valid, tag, line data); valid bits in flops, clearable in one cycle; per-set replacement pointer of `log2(WAYS)` bits (absent for `WAYS=1`).
- FSM: `RUN`, `FILL`, `WRITE`.
- `RUN`: when `Instr_req=1`, register address and read all ways at index. Next cycle compare tags; `hit` = any way valid with matching tag; `instruction` = word `[OFF_W+1:2]` of that way. With `Instr_req=0`, registered address and data hold.
- Miss (`Instr_req_dly & ~hit`): latch miss address, enter `FILL`, assert `DRAM_req` next cycle with `DRAM_req_addr`.
- `FILL`: each `DRAM_valid` beat stored at word `beat_cnt`, `beat_cnt++`. `DRAM_valid` outside `FILL` is ignored. On beat `LINE_WORDS-1`: deassert `DRAM_req` next cycle, go `WRITE`.
- `WRITE`: victim = lowest-numbered invalid way in set, else way at replacement pointer; write tag, data, valid=1; advance pointer modulo `WAYS` only when a valid way was evicted. Re-read the miss address; return to `RUN`; the re-read hits.
- Hits do not change the replacement pointer (round-robin, not LRU).
- `flush` in `RUN`: clear all valid bits and replacement pointers that edge; a lookup registered the same cycle reads pre-flush data but its hit check next cycle sees cleared valids (miss). `flush` in `FILL`/`WRITE`: latched, applied on the cycle after `WRITE`, so the refilled line is invalidated too.
- `rom_abort = (Instr_req_dly & ~hit) | (state != RUN) | DRAM_req`.

## Timing
- Reset (`RESET=0` at edge): state `RUN`, all valids 0, pointers 0, `beat_cnt` 0, `DRAM_req` 0, `DRAM_req_addr` 0, registered address/data 0, so `instruction` 0, `hit` 0, `rom_abort` 0, counters 0. Reset mid-fill abandons the fill; late DRAM beats are ignored.
- Hit latency: request cycle N → `hit`/`instruction` valid cycle N+1.
- Miss: `hit=0`, `rom_abort=1` at N+1; `DRAM_req=1` at N+2; last beat at cycle L → `DRAM_req=0` and `WRITE` at L+1; `RUN` with valid re-read data at L+2; IF replays, hit at replay+1.
- Back-to-back hits: one per cycle, no bubbles.
- New `Instr_req` while not in `RUN` does not update the registered address.

## Configuration
- `ICACHE_STATS_EN` defined: `hit_count` increments per lookup cycle with `Instr_req_dly & hit & state==RUN`; `miss_count` increments on each `RUN`→`FILL`; both wrap at 2^32; cleared by reset, not by `flush`.
- Undefined: counters not built; `hit_count` and `miss_count` tied to 0.

## Test plan
- Cold miss, default params: request 0x0000_0104 → `hit=0`, `rom_abort=1`, `DRAM_req_addr=0x0000_0040`; beats 0xA0..0xA7 → replay hits with `instruction=0xA1`.
- Sequential stream 0x100..0x11C after fill → eight consecutive hits, `rom_abort=0`, words 0xA0..0xA7.
- 2-way conflict: fill tags for 0x0000_0100, 0x0000_2100, 0x0000_4100 (same set) → third fill evicts way 0 (0x100 now misses), 0x2100 still hits.
- `flush` pulse after fills → next request to 0x100 misses; `flush` during `FILL` → refilled line misses on replay.
- Reset asserted mid-fill after 3 beats → `DRAM_req=0`, all outputs zero; stray `DRAM_valid` ignored; next request to same line misses cleanly.
- With `ICACHE_STATS_EN`: 1 miss + 9 hits → `miss_count=1`, `hit_count=9`; without, both 0.

Source files
------------

// File: rtl/i_cache_sa.sv
// i_cache_sa: set-associative I-cache, round-robin refill from DRAM, whole-cache flush; ICACHE_STATS_EN builds hit/miss counters
module i_cache_sa #(
  parameter int WAYS       = 2,
  parameter int SETS       = 256,
  parameter int LINE_WORDS = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IF_address,
  input  logic        Instr_req,
  input  logic        flush,
  input  logic [31:0] DRAM_data,
  input  logic        DRAM_valid,
  output logic        DRAM_req,
  output logic [31:0] DRAM_req_addr,
  output logic [31:0] instruction,
  output logic        hit,
  output logic        rom_abort,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam int PTR_W = WAYS > 1 ? $clog2(WAYS) : 1;
  typedef enum logic [1:0] {RUN, FILL, WRITE} state_t;
  state_t            r_state;
  logic [31:2]       r_addr;
  logic              r_req_dly;
  logic [OFF_W-1:0]  r_beat;
  logic [PTR_W-1:0]  r_vic;
  logic              r_evict;
  logic              r_flush_pend;
  logic [SETS-1:0]   r_valid [WAYS];
  logic [TAG_W-1:0]  r_tag   [WAYS][SETS];
  logic [31:0]       r_data  [WAYS][SETS][LINE_WORDS];
  logic [PTR_W-1:0]  r_ptr   [SETS];
  logic [31:0]       r_rd_word [WAYS];
  logic [IDX_W-1:0]  w_idx, w_rd_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [OFF_W-1:0]  w_rd_off;
  logic [WAYS-1:0]   w_match;
  logic [PTR_W-1:0]  w_vic;
  logic              w_all_valid, w_miss, w_accept, w_last, w_unused;
  assign w_idx    = r_addr[OFF_W+IDX_W+1:OFF_W+2];
  assign w_tag    = r_addr[31:OFF_W+IDX_W+2];
  assign w_rd_idx = (r_state == WRITE) ? w_idx : IF_address[OFF_W+IDX_W+1:OFF_W+2];
  assign w_rd_off = (r_state == WRITE) ? r_addr[OFF_W+1:2] : IF_address[OFF_W+1:2];
  assign w_last   = r_beat == OFF_W'(LINE_WORDS - 1);
  assign w_unused = ^IF_address[1:0];
  // tags and valids are checked live so a flush on the request edge already forces a miss
  always_comb begin
    w_match     = '0;
    instruction = '0;
    w_vic       = r_ptr[w_idx];
    w_all_valid = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      w_match[w] = r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag);
      instruction = w_match[w] ? (instruction | r_rd_word[w]) : instruction;
      if (!r_valid[w][w_idx]) begin
        w_vic       = PTR_W'(w);
        w_all_valid = 1'b0;
      end
    end
  end
  assign hit       = |w_match;
  assign w_miss    = r_req_dly & ~hit;
  assign w_accept  = Instr_req & (r_state == RUN) & ~w_miss;
  assign rom_abort = w_miss | (r_state != RUN) | DRAM_req;
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state       <= RUN;
      r_addr        <= '0;
      r_req_dly     <= 1'b0;
      r_beat        <= '0;
      r_vic         <= '0;
      r_evict       <= 1'b0;
      r_flush_pend  <= 1'b0;
      DRAM_req      <= 1'b0;
      DRAM_req_addr <= '0;
      for (int w = 0; w < WAYS; w++) begin
        r_valid[w]   <= '0;
        r_rd_word[w] <= '0;
      end
      for (int s = 0; s < SETS; s++) r_ptr[s] <= '0;
    end else begin
      r_req_dly <= w_accept;
      if (w_accept) r_addr <= IF_address[31:2];
      if (w_accept || r_state == WRITE)
        for (int w = 0; w < WAYS; w++) r_rd_word[w] <= r_data[w][w_rd_idx][w_rd_off];
      case (r_state)
        RUN: begin
          if (flush || r_flush_pend) begin
            for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
            for (int s = 0; s < SETS; s++) r_ptr[s] <= '0;
            r_flush_pend <= 1'b0;
          end
          if (w_miss) begin
            r_state       <= FILL;
            r_vic         <= w_vic;
            r_evict       <= w_all_valid;
            r_beat        <= '0;
            DRAM_req      <= 1'b1;
            DRAM_req_addr <= {2'b00, r_addr[31:OFF_W+2], {OFF_W{1'b0}}};
          end
        end
        FILL: begin
          r_flush_pend <= r_flush_pend | flush;
          if (DRAM_valid) begin
            r_beat <= r_beat + OFF_W'(1);
            if (w_last) begin
              DRAM_req <= 1'b0;
              r_state  <= WRITE;
            end
          end
        end
        default: begin
          r_flush_pend            <= r_flush_pend | flush;
          r_valid[r_vic][w_idx]   <= 1'b1;
          if (r_evict && WAYS > 1) r_ptr[w_idx] <= r_vic + PTR_W'(1);
          r_state                 <= RUN;
        end
      endcase
    end
  end
  // beats land straight in the victim line; a stale valid bit there is cleared by reset or rewritten in WRITE
  always_ff @(posedge CLK) begin
    if (RESET && r_state == FILL && DRAM_valid) r_data[r_vic][w_idx][r_beat] <= DRAM_data;
    if (RESET && r_state == WRITE) r_tag[r_vic][w_idx] <= w_tag;
  end
`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (r_req_dly && hit && r_state == RUN) r_hit_cnt <= r_hit_cnt + 32'd1;
      if (r_state == RUN && w_miss) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end
  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif
endmodule
